// File: rtl/id_operand_stage.sv
// RV32I decode/operand stage: register file, EX>MEM>WB operand forwarding,
// load-use/no-forward interlock, and the ID/EX pipeline register.
module id_operand_stage #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int LOAD_LAT = 1,
  parameter  int FWD_EN   = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_id_vld,
  input  logic [31:0]     i_instr_id,
  input  logic [XLEN-1:0] i_pc_id,
  input  logic            i_flush,
  input  logic [AW-1:0]   i_ex_rd_addr,
  input  logic [AW-1:0]   i_mem_rd_addr,
  input  logic [AW-1:0]   i_wb_rd_addr,
  input  logic            i_ex_rd_wren,
  input  logic            i_mem_rd_wren,
  input  logic            i_wb_rd_wren,
  input  logic            i_ex_is_load,
  input  logic            i_mem_is_load,
  input  logic [XLEN-1:0] i_ex_data,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_idex_vld,
  output logic [31:0]     o_idex_instr,
  output logic [XLEN-1:0] o_idex_pc,
  output logic [XLEN-1:0] o_idex_rs1_data,
  output logic [XLEN-1:0] o_idex_rs2_data,
  output logic [AW-1:0]   o_idex_rs1_addr,
  output logic [AW-1:0]   o_idex_rs2_addr,
  output logic [AW-1:0]   o_idex_rd_addr
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [XLEN-1:0] rf [NREG];

  logic [6:0]      opc_p0;
  logic [AW-1:0]   src_a_p0    [2];
  logic            src_used_p0 [2];
  logic            ex_hit_p0   [2];
  logic            mem_hit_p0  [2];
  logic            wb_hit_p0   [2];
  logic            haz_p0      [2];
  logic [XLEN-1:0] opnd_p0     [2];
  logic [AW-1:0]   rd_a_p0;
  logic            ex_fwd_ok_p0;
  logic            mem_fwd_ok_p0;

  logic            vld_p1;
  logic [31:0]     instr_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [AW-1:0]   rs1_addr_p1;
  logic [AW-1:0]   rs2_addr_p1;
  logic [AW-1:0]   rd_addr_p1;

  // ID stage: decode, operand resolution and interlock
  assign opc_p0         = i_instr_id[6:0];
  assign src_a_p0[0]    = AW'(i_instr_id[19:15]);
  assign src_a_p0[1]    = AW'(i_instr_id[24:20]);
  assign rd_a_p0        = AW'(i_instr_id[11:7]);
  assign src_used_p0[0] = !(opc_p0 == OPC_LUI || opc_p0 == OPC_AUIPC || opc_p0 == OPC_JAL);
  assign src_used_p0[1] = (opc_p0 == OPC_OP || opc_p0 == OPC_STORE || opc_p0 == OPC_BRANCH);

  // A matching producer whose result cannot be forwarded yet forces a stall.
  assign ex_fwd_ok_p0  = (FWD_EN != 0) && !i_ex_is_load;
  assign mem_fwd_ok_p0 = (FWD_EN != 0) && (!i_mem_is_load || LOAD_LAT == 1);

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ex_hit_p0[k]  = 1'b0;
      mem_hit_p0[k] = 1'b0;
      wb_hit_p0[k]  = 1'b0;
      haz_p0[k]     = 1'b0;
      opnd_p0[k]    = '0;
    end
    for (int k = 0; k < 2; k++) begin
      ex_hit_p0[k]  = src_used_p0[k] && (src_a_p0[k] != '0) &&
                      i_ex_rd_wren && (i_ex_rd_addr == src_a_p0[k]);
      mem_hit_p0[k] = src_used_p0[k] && (src_a_p0[k] != '0) &&
                      i_mem_rd_wren && (i_mem_rd_addr == src_a_p0[k]);
      wb_hit_p0[k]  = (src_a_p0[k] != '0) && i_wb_rd_wren && (i_wb_rd_addr == src_a_p0[k]);
      haz_p0[k]     = (ex_hit_p0[k] && !ex_fwd_ok_p0) || (mem_hit_p0[k] && !mem_fwd_ok_p0);
      if (src_a_p0[k] == '0)
        opnd_p0[k] = '0;
      else if (ex_hit_p0[k] && ex_fwd_ok_p0)
        opnd_p0[k] = i_ex_data;
      else if (mem_hit_p0[k] && mem_fwd_ok_p0)
        opnd_p0[k] = i_mem_data;
      else if (wb_hit_p0[k])
        opnd_p0[k] = i_wb_data;
      else
        opnd_p0[k] = rf[src_a_p0[k]];
    end
  end

  assign o_stall = i_id_vld && !i_flush && (haz_p0[0] || haz_p0[1]);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (i_wb_rd_wren && (i_wb_rd_addr != '0)) begin
      rf[i_wb_rd_addr] <= i_wb_data;
    end
  end

  // ID/EX register: a stall inserts a bubble while the payload holds
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rd_addr_p1  <= '0;
    end else if (i_flush || o_stall) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1      <= i_id_vld;
      instr_p1    <= i_instr_id;
      pc_p1       <= i_pc_id;
      rs1_data_p1 <= opnd_p0[0];
      rs2_data_p1 <= opnd_p0[1];
      rs1_addr_p1 <= src_a_p0[0];
      rs2_addr_p1 <= src_a_p0[1];
      rd_addr_p1  <= rd_a_p0;
    end
  end

  assign o_idex_vld      = vld_p1;
  assign o_idex_instr    = instr_p1;
  assign o_idex_pc       = pc_p1;
  assign o_idex_rs1_data = rs1_data_p1;
  assign o_idex_rs2_data = rs2_data_p1;
  assign o_idex_rs1_addr = rs1_addr_p1;
  assign o_idex_rs2_addr = rs2_addr_p1;
  assign o_idex_rd_addr  = rd_addr_p1;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: three configurations (LL1/FWD, LL2/FWD, LL1/no-FWD)
// driven in lockstep and compared against a rule-level reference model.
module tb_id_operand_stage;

  localparam int NC = 3;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] OP = 7'b0110011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] OPIMM = 7'b0010011, LOAD = 7'b0000011, JALR = 7'b1100111;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_reset, i_id_vld, i_flush;
  logic [31:0] i_instr_id, i_pc_id;
  logic [4:0]  i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr;
  logic        i_ex_rd_wren, i_mem_rd_wren, i_wb_rd_wren, i_ex_is_load, i_mem_is_load;
  logic [31:0] i_ex_data, i_mem_data, i_wb_data;

  logic        stall_o [NC];
  logic        vld_o   [NC];
  logic [31:0] instr_o [NC], pc_o [NC], d1_o [NC], d2_o [NC];
  logic [4:0]  a1_o    [NC], a2_o [NC], rd_o [NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    id_operand_stage #(.XLEN(32), .NREG(32), .LOAD_LAT(g == 1 ? 2 : 1), .FWD_EN(g == 2 ? 0 : 1)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_id_vld(i_id_vld), .i_instr_id(i_instr_id),
      .i_pc_id(i_pc_id), .i_flush(i_flush),
      .i_ex_rd_addr(i_ex_rd_addr), .i_mem_rd_addr(i_mem_rd_addr), .i_wb_rd_addr(i_wb_rd_addr),
      .i_ex_rd_wren(i_ex_rd_wren), .i_mem_rd_wren(i_mem_rd_wren), .i_wb_rd_wren(i_wb_rd_wren),
      .i_ex_is_load(i_ex_is_load), .i_mem_is_load(i_mem_is_load),
      .i_ex_data(i_ex_data), .i_mem_data(i_mem_data), .i_wb_data(i_wb_data),
      .o_stall(stall_o[g]), .o_idex_vld(vld_o[g]), .o_idex_instr(instr_o[g]), .o_idex_pc(pc_o[g]),
      .o_idex_rs1_data(d1_o[g]), .o_idex_rs2_data(d2_o[g]),
      .o_idex_rs1_addr(a1_o[g]), .o_idex_rs2_addr(a2_o[g]), .o_idex_rd_addr(rd_o[g]));
  end

  int tests = 0;
  int fails = 0;

  // Reference state: architectural registers and the expected ID/EX contents per config
  logic [31:0] m_rf [32];
  logic        m_vld [NC];
  logic [31:0] m_instr [NC], m_pc [NC], m_d1 [NC], m_d2 [NC];
  logic [14:0] m_addrs [NC];

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, 3'b000, rd, OP};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (i_wb_rd_wren && i_wb_rd_addr == a) return i_wb_data;
    return m_rf[a];
  endfunction

  // A register value is obtainable from a stage only if that stage's data already holds it;
  // any matching stage that cannot supply it yet blocks issue.
  function automatic void model_eval(input int c, output logic st, output logic [31:0] d1, output logic [31:0] d2);
    logic [6:0]  op;
    logic        used [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];
    logic [4:0]  sa [2];
    logic        sw [2], sok [2], found;
    logic [31:0] sd [2];
    logic        haz;
    int          ll, fe;
    ll = (c == 1) ? 2 : 1;
    fe = (c == 2) ? 0 : 1;
    op = i_instr_id[6:0];
    used[0] = !(op inside {LUI, AUIPC, JAL});
    used[1] = op inside {OP, STORE, BRANCH};
    a[0] = i_instr_id[19:15];
    a[1] = i_instr_id[24:20];
    sa = '{i_ex_rd_addr, i_mem_rd_addr};
    sw = '{i_ex_rd_wren, i_mem_rd_wren};
    sd = '{i_ex_data, i_mem_data};
    sok[0] = (fe == 1) && !i_ex_is_load;
    sok[1] = (fe == 1) && (!i_mem_is_load || ll == 1);
    haz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d[k] = rf_read(a[k]);
      found = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (used[k] && a[k] != 5'd0 && sw[s] && sa[s] == a[k]) begin
          if (!sok[s]) haz = 1'b1;
          else if (!found) begin d[k] = sd[s]; found = 1'b1; end
        end
      end
    end
    st = i_id_vld && !i_flush && haz;
    d1 = d[0];
    d2 = d[1];
  endfunction

  task automatic check_regs();
    for (int c = 0; c < NC; c++) begin
      chk("vld", c, 32'(vld_o[c]), 32'(m_vld[c]));
      chk("instr", c, instr_o[c], m_instr[c]);
      chk("pc", c, pc_o[c], m_pc[c]);
      chk("rs1_data", c, d1_o[c], m_d1[c]);
      chk("rs2_data", c, d2_o[c], m_d2[c]);
      chk("addrs", c, 32'({a1_o[c], a2_o[c], rd_o[c]}), 32'(m_addrs[c]));
    end
  endtask

  // Entered at posedge+1; leaves at the following posedge+1 with outputs checked.
  task automatic step();
    logic        s [NC];
    logic [31:0] x1 [NC], x2 [NC];
    #2;
    for (int c = 0; c < NC; c++) begin
      model_eval(c, s[c], x1[c], x2[c]);
      chk("stall", c, 32'(stall_o[c]), 32'(s[c]));
    end
    @(posedge i_clk);
    for (int c = 0; c < NC; c++) begin
      if (i_flush || s[c]) m_vld[c] = 1'b0;
      else begin
        m_vld[c]   = i_id_vld;
        m_instr[c] = i_instr_id;
        m_pc[c]    = i_pc_id;
        m_d1[c]    = x1[c];
        m_d2[c]    = x2[c];
        m_addrs[c] = {i_instr_id[19:15], i_instr_id[24:20], i_instr_id[11:7]};
      end
    end
    if (i_wb_rd_wren && i_wb_rd_addr != 5'd0) m_rf[i_wb_rd_addr] = i_wb_data;
    #1;
    check_regs();
  endtask

  task automatic idle();
    i_id_vld = 0; i_instr_id = 0; i_pc_id = 0; i_flush = 0;
    i_ex_rd_addr = 0; i_mem_rd_addr = 0; i_wb_rd_addr = 0;
    i_ex_rd_wren = 0; i_mem_rd_wren = 0; i_wb_rd_wren = 0;
    i_ex_is_load = 0; i_mem_is_load = 0;
    i_ex_data = 0; i_mem_data = 0; i_wb_data = 0;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #2;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
    for (int c = 0; c < NC; c++) begin
      m_vld[c] = 0; m_instr[c] = 0; m_pc[c] = 0; m_d1[c] = 0; m_d2[c] = 0; m_addrs[c] = 0;
    end
    check_regs();
    for (int c = 0; c < NC; c++) chk("rst_stall", c, 32'(stall_o[c]), 32'h0);
    i_reset = 1'b1;
  endtask

  initial begin
    idle();
    i_reset = 1'b1;
    #1;
    do_reset();
    @(posedge i_clk);
    #1;

    // EX forwarding beats a same-cycle WB write to the same register
    idle();
    i_wb_rd_wren = 1; i_wb_rd_addr = 5'd3; i_wb_data = 32'h11;
    i_ex_rd_wren = 1; i_ex_rd_addr = 5'd3; i_ex_data = 32'h22;
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd4, 5'd3, 5'd3); i_pc_id = 32'h100;
    step();
    for (int c = 0; c < 2; c++) begin
      chk("exfwd_rs1", c, d1_o[c], 32'h22);
      chk("exfwd_rs2", c, d2_o[c], 32'h22);
    end
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd4, 5'd3, 5'd0); i_pc_id = 32'h104;
    step();
    for (int c = 0; c < NC; c++) chk("rf_x3", c, d1_o[c], 32'h11);

    // Load-use: producer walks EX -> MEM -> WB while ID holds the consumer
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h20, 5'd8, 5'd7, 5'd1); i_pc_id = 32'h108;
    i_ex_rd_wren = 1; i_ex_rd_addr = 5'd7; i_ex_is_load = 1;
    #1;
    for (int c = 0; c < NC; c++) chk("lu_stall_ex", c, 32'(stall_o[c]), 32'h1);
    step();
    for (int c = 0; c < NC; c++) chk("lu_bubble", c, 32'(vld_o[c]), 32'h0);
    i_ex_rd_wren = 0; i_ex_is_load = 0; i_ex_rd_addr = 0;
    i_mem_rd_wren = 1; i_mem_rd_addr = 5'd7; i_mem_is_load = 1; i_mem_data = 32'hDEAD;
    #1;
    chk("lu_stall_mem", 0, 32'(stall_o[0]), 32'h0);
    chk("lu_stall_mem", 1, 32'(stall_o[1]), 32'h1);
    chk("lu_stall_mem", 2, 32'(stall_o[2]), 32'h1);
    step();
    chk("lu_memfwd_vld", 0, 32'(vld_o[0]), 32'h1);
    chk("lu_memfwd", 0, d1_o[0], 32'hDEAD);
    chk("lu_ll2_bubble", 1, 32'(vld_o[1]), 32'h0);
    i_mem_rd_wren = 0; i_mem_is_load = 0; i_mem_rd_addr = 0;
    i_wb_rd_wren = 1; i_wb_rd_addr = 5'd7; i_wb_data = 32'hDEAD;
    #1;
    for (int c = 0; c < NC; c++) chk("lu_stall_wb", c, 32'(stall_o[c]), 32'h0);
    step();
    for (int c = 0; c < NC; c++) begin
      chk("lu_wb_vld", c, 32'(vld_o[c]), 32'h1);
      chk("lu_wb_bypass", c, d1_o[c], 32'hDEAD);
    end

    // x0 never forwarded; LUI ignores its rs1 field
    idle();
    i_ex_rd_wren = 1; i_ex_rd_addr = 5'd0; i_ex_data = 32'h55;
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd10, 5'd0, 5'd0); i_pc_id = 32'h10C;
    step();
    for (int c = 0; c < NC; c++) begin
      chk("x0_rs1", c, d1_o[c], 32'h0);
      chk("x0_vld", c, 32'(vld_o[c]), 32'h1);
    end
    idle();
    i_ex_rd_wren = 1; i_ex_rd_addr = 5'd7; i_ex_is_load = 1;
    i_id_vld = 1; i_instr_id = {20'h12345, 5'd9, LUI}; i_instr_id[19:15] = 5'd7; i_pc_id = 32'h110;
    #1;
    for (int c = 0; c < NC; c++) chk("lui_nostall", c, 32'(stall_o[c]), 32'h0);
    step();

    // Flush overrides a load-use hazard; only the WB write lands
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h20, 5'd8, 5'd7, 5'd1); i_pc_id = 32'h114;
    i_ex_rd_wren = 1; i_ex_rd_addr = 5'd7; i_ex_is_load = 1; i_flush = 1;
    i_wb_rd_wren = 1; i_wb_rd_addr = 5'd12; i_wb_data = 32'h77;
    #1;
    for (int c = 0; c < NC; c++) chk("flush_stall", c, 32'(stall_o[c]), 32'h0);
    step();
    for (int c = 0; c < NC; c++) chk("flush_vld", c, 32'(vld_o[c]), 32'h0);
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd13, 5'd12, 5'd7); i_pc_id = 32'h118;
    step();
    for (int c = 0; c < NC; c++) begin
      chk("flush_x12", c, d1_o[c], 32'h77);
      chk("flush_x7", c, d2_o[c], 32'hDEAD);
    end

    // Randomised traffic with frequent register-address collisions
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [9];
      ops = '{OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR};
      i_instr_id = $urandom;
      i_instr_id[6:0]   = ops[$urandom_range(0, 8)];
      i_instr_id[19:15] = 5'($urandom_range(0, 3));
      i_instr_id[24:20] = 5'($urandom_range(0, 3));
      i_instr_id[11:7]  = 5'($urandom_range(0, 31));
      i_pc_id  = $urandom;
      i_id_vld = ($urandom_range(0, 4) != 0);
      i_flush  = ($urandom_range(0, 9) == 0);
      i_ex_rd_addr  = 5'($urandom_range(0, 3));
      i_mem_rd_addr = 5'($urandom_range(0, 3));
      i_wb_rd_addr  = 5'($urandom_range(0, 3));
      i_ex_rd_wren  = $urandom_range(0, 1) == 1;
      i_mem_rd_wren = $urandom_range(0, 1) == 1;
      i_wb_rd_wren  = $urandom_range(0, 1) == 1;
      i_ex_is_load  = $urandom_range(0, 2) == 0;
      i_mem_is_load = $urandom_range(0, 2) == 0;
      i_ex_data  = $urandom;
      i_mem_data = $urandom;
      i_wb_data  = $urandom;
      step();
    end

    // Asynchronous reset with a valid instruction in ID/EX
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd1, 5'd2, 5'd3); i_pc_id = 32'h200;
    step();
    for (int c = 0; c < NC; c++) chk("pre_rst_vld", c, 32'(vld_o[c]), 32'h1);
    do_reset();
    idle();
    i_id_vld = 1; i_instr_id = mk_r(7'h00, 5'd1, 5'd5, 5'd0); i_pc_id = 32'h204;
    step();
    for (int c = 0; c < NC; c++) chk("post_rst_x5", c, d1_o[c], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Parametrised decode/operand stage for the five-stage RV32I pipeline. It owns the integer register file, resolves RAW hazards internally (EX > MEM > WB forwarding, load-use interlock), and registers decoded operands into the ID/EX pipeline register. Upstream, it sits behind the IF/ID register. Downstream, it feeds the EX stage. It also produces the stall for the IF stage and PC.

Parameters:
XLEN, 32, data/PC width in bits
NREG, 32, architectural registers (x0 hardwired zero); address width AW = clog2(NREG)
LOAD_LAT, 1, load data available at MEM output (1) or at WB only (2)
FWD_EN, 1, 1 = forwarding from EX/MEM; 0 = stall until producer reaches WB

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_id_vld  in  1  IF/ID holds a valid instruction
i_instr_id  in  32  instruction in ID
i_pc_id  in  XLEN  PC of ID instruction
i_flush  in  1  branch/jump redirect from EX; squash ID
i_ex_rd_addr / i_mem_rd_addr / i_wb_rd_addr  in  AW  destination of EX/MEM/WB instruction
i_ex_rd_wren / i_mem_rd_wren / i_wb_rd_wren  in  1  stage writes rd (qualified by stage valid)
i_ex_is_load / i_mem_is_load  in  1  producer is a load
i_ex_data / i_mem_data / i_wb_data  in  XLEN  stage result (i_mem_data = load data when LOAD_LAT=1)
o_stall  out  1  hold PC and IF/ID this cycle
o_idex_vld  out  1  ID/EX holds valid instruction
o_idex_instr  out  32  registered instruction
o_idex_pc  out  XLEN  registered PC
o_idex_rs1_data / o_idex_rs2_data  out  XLEN  registered resolved operands
o_idex_rs1_addr / o_idex_rs2_addr / o_idex_rd_addr  out  AW  registered addresses

Behaviour:
- Reset (i_reset=0, async): all ID/EX outputs 0, o_idex_vld=0, all registers = 0. Because o_stall is combinational, it reads 0 when i_id_vld=0. Reset mid-stall clears immediately, with no residual interlock.
- Register file: write on posedge when i_wb_rd_wren and i_wb_rd_addr!=0. Combinational read with same-cycle WB bypass. x0 always reads 0 and is never written.
- Operand use decode (opcode [6:0]): rs1 unused for LUI/AUIPC/JAL. rs2 used only for OP, STORE, BRANCH. An unused operand or an address of 0 never causes a hazard or a forward.
- Forward selection per operand, priority EX > MEM > WB > regfile; each source requires wren=1 and addr match:
  - EX: forward i_ex_data only if FWD_EN=1 and !i_ex_is_load.
  - MEM: forward i_mem_data if FWD_EN=1, and either !i_mem_is_load or LOAD_LAT=1.
  - WB: always forwarded, through the regfile bypass.
- Hazard (o_stall=1) when i_id_vld, !i_flush, and any used operand matches:
  - EX producer that is a load, or any EX producer when FWD_EN=0;
  - MEM producer that is a load with LOAD_LAT=2, or any MEM producer when FWD_EN=0.
- Latency: one cycle, ID to ID/EX register.
- On each posedge:
  - if i_flush: o_idex_vld<=0.
  - else if o_stall: o_idex_vld<=0 (bubble), payload fields hold.
  - else: o_idex_vld<=i_id_vld and all payload fields load.
- i_flush has priority over hazard and forces o_stall=0.
- Stall length is emergent: 1 cycle for load-use with LOAD_LAT=1, 2 cycles with LOAD_LAT=2, up to 2 cycles with FWD_EN=0. No internal counter. The condition re-evaluates each cycle as the producer advances.

Test Plan:
- Reset: assert i_reset=0 mid-run with o_idex_vld=1 -> outputs 0 immediately. After release, reading x5 returns 0.
- EX forward: WB writes x3=0x11. EX holds non-load rd=x3, data 0x22. ID holds `add x4,x3,x3` -> next cycle both rs data=0x22, o_stall=0.
- Load-use, LOAD_LAT=1: EX is `lw x7` and ID is `sub x8,x7,x1` -> o_stall=1 for exactly 1 cycle with a bubble (vld=0). Next cycle the MEM load data 0xDEAD is forwarded.
- LOAD_LAT=2 / FWD_EN=0: the same sequence stalls 2 cycles, and the operand then comes from the WB bypass in the same cycle as the write.
- x0 and unused operands: EX writes x0=0x55 and ID uses x0 -> operand 0, no stall. `lui x9` with rs1 field = EX rd -> no stall.
- Flush vs stall: a load-use hazard with i_flush=1 in the same cycle -> o_stall=0 and o_idex_vld=0 next cycle. Registers are unchanged except the WB write.
